// File: rtl/cla_pipe_adder32.sv
// Two-stage pipelined adder built from 4-bit carry-lookahead slices with valid/ready on both sides.
// Define CLA_OVF_FLAG_EN to add the registered signed-overflow output out_ovf.
module cla_pipe_adder32 #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int HI_W      = WIDTH - SPLIT;
    localparam int LO_SLICES = SPLIT / 4;
    localparam int HI_SLICES = HI_W / 4;

    // One 4-bit lookahead slice: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cc;
        g     = a & b;
        p     = a ^ b;
        cc[0] = c;
        cc[1] = g[0] | (p[0] & c);
        cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        return {cc[4], p ^ cc[3:0]};
    endfunction

    logic             r_s1_valid;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_c;
    logic [HI_W-1:0]  r_s1_a_hi;
    logic [HI_W-1:0]  r_s1_b_hi;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s1_en;
    logic             w_s2_en;
    logic [SPLIT-1:0] w_lo_sum;
    logic             w_lo_c;
    logic [HI_W-1:0]  w_hi_sum;
    logic             w_hi_c;

    assign w_s2_en  = !r_s2_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic [4:0] w_slice;
        w_lo_sum = '0;
        w_lo_c   = in_cin;
        for (int k = 0; k < LO_SLICES; k++) begin
            w_slice           = cla4(in_a[4*k +: 4], in_b[4*k +: 4], w_lo_c);
            w_lo_sum[4*k +: 4] = w_slice[3:0];
            w_lo_c            = w_slice[4];
        end
    end

    always_comb begin
        logic [4:0] w_slice;
        w_hi_sum = '0;
        w_hi_c   = r_s1_c;
        for (int k = 0; k < HI_SLICES; k++) begin
            w_slice            = cla4(r_s1_a_hi[4*k +: 4], r_s1_b_hi[4*k +: 4], w_hi_c);
            w_hi_sum[4*k +: 4] = w_slice[3:0];
            w_hi_c             = w_slice[4];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lo    <= '0;
            r_s1_c     <= 1'b0;
            r_s1_a_hi  <= '0;
            r_s1_b_hi  <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            r_s1_lo    <= w_lo_sum;
            r_s1_c     <= w_lo_c;
            r_s1_a_hi  <= in_a[WIDTH-1:SPLIT];
            r_s1_b_hi  <= in_b[WIDTH-1:SPLIT];
        end
    end

    // Output registers hold while out_valid & !out_ready, keeping the result stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            r_sum      <= {w_hi_sum, r_s1_lo};
            r_cout     <= w_hi_c;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

`ifdef CLA_OVF_FLAG_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (r_s1_a_hi[HI_W-1] == r_s1_b_hi[HI_W-1]) && (w_hi_sum[HI_W-1] != r_s1_a_hi[HI_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_s2_en) begin
            r_ovf <= w_ovf;
        end
    end

    assign out_ovf = r_ovf;
`endif

endmodule
